// File: rtl/multichannel_pwm_modulator_pkg.sv
// Shared types and sizing for the multichannel PWM modulator.
// Defining PWM_DITHER_EN enables the first-order dithered fractional width.
package pwm_pkg;

   localparam int PWM_BITS     = 11;
   localparam int PWM_CHANNELS = 4;
   localparam int PWM_FRAC     = 4;
   localparam int PW_W         = PWM_BITS + PWM_FRAC;

`ifdef PWM_DITHER_EN
   localparam bit DITHER_EN = 1'b1;
`else
   localparam bit DITHER_EN = 1'b0;
`endif

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } pwm_dir_e;

endpackage

// File: rtl/multichannel_pwm_modulator_if.sv
// Width-load handshake bundle: per-channel widths with valid/ready.
interface multichannel_pwm_modulator_if
   import pwm_pkg::*;
#(
   parameter int BITS     = PWM_BITS,
   parameter int CHANNELS = PWM_CHANNELS,
   parameter int FRAC     = PWM_FRAC
);
   logic [CHANNELS*(BITS+FRAC)-1:0] pw_data;
   logic                            pw_valid;
   logic                            pw_ready;

   modport master (output pw_data, output pw_valid, input  pw_ready);
   modport slave  (input  pw_data, input  pw_valid, output pw_ready);
endinterface

// File: rtl/multichannel_pwm_modulator_channel.sv
// One PWM channel: shadow width, active width, optional dither accumulator
// (PWM_DITHER_EN) and the registered comparator against the shared counter.
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int BITS = PWM_BITS,
   parameter int FRAC = PWM_FRAC,
   parameter int IN_W = BITS + (DITHER_EN ? FRAC : 0)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            apply,
   input  logic [IN_W-1:0] pw_in,
   input  logic [BITS-1:0] cnt,
   output logic            pwm
);
   logic [IN_W-1:0] shadow_r;
   logic [BITS-1:0] active_r;
   logic [BITS-1:0] next_width_s;
   logic            pwm_r;

`ifdef PWM_DITHER_EN
   logic [FRAC-1:0] acc_r;
   logic [FRAC:0]   acc_sum_s;
   logic [BITS:0]   int_sum_s;

   // Fractional accumulation; the carry bumps the integer width, saturating at all-ones.
   always_comb begin
      acc_sum_s = {1'b0, acc_r} + {1'b0, shadow_r[FRAC-1:0]};
      int_sum_s = {1'b0, shadow_r[IN_W-1:FRAC]} + {{BITS{1'b0}}, acc_sum_s[FRAC]};
      if (int_sum_s[BITS]) begin
         next_width_s = {BITS{1'b1}};
      end else begin
         next_width_s = int_sum_s[BITS-1:0];
      end
   end

   // Accumulator advances at every apply so the dither keeps running without new writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_r <= {FRAC{1'b0}};
      end else if (apply) begin
         acc_r <= acc_sum_s[FRAC-1:0];
      end else begin
         acc_r <= acc_r;
      end
   end
`else
   assign next_width_s = shadow_r;
`endif

   // Shadow load, boundary transfer and registered compare.
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_r <= {IN_W{1'b0}};
         active_r <= {BITS{1'b0}};
         pwm_r    <= 1'b0;
      end else begin
         if (load) begin
            shadow_r <= pw_in;
         end else begin
            shadow_r <= shadow_r;
         end
         if (apply) begin
            active_r <= next_width_s;
         end else begin
            active_r <= active_r;
         end
         pwm_r <= (cnt < active_r);
      end
   end

   assign pwm = pwm_r;
endmodule

// File: rtl/multichannel_pwm_modulator.sv
// Shared period counter (sawtooth or triangle), boundary detection and width
// handshake driving CHANNELS pwm_channel instances. Dither option: PWM_DITHER_EN.
module multichannel_pwm_modulator
   import pwm_pkg::*;
#(
   parameter int BITS     = PWM_BITS,
   parameter int CHANNELS = PWM_CHANNELS,
   parameter int FRAC     = PWM_FRAC
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        dual_slope_en,
   input  logic [BITS-1:0]             compare_max,
   multichannel_pwm_modulator_if.slave pw_bus,
   output logic                        pulse_done,
   output logic [CHANNELS-1:0]         pwm_out
);
   localparam int CH_W = BITS + FRAC;
   localparam int IN_W = BITS + (DITHER_EN ? FRAC : 0);
   localparam logic [BITS-1:0] CNT_ZERO = {BITS{1'b0}};
   localparam logic [BITS-1:0] CNT_ONE  = {{(BITS-1){1'b0}}, 1'b1};

   pwm_dir_e        dir_r, dir_nxt_s;
   logic [BITS-1:0] cnt_r, cnt_nxt_s;
   logic [BITS-1:0] max_r, max_nxt_s;
   logic            dual_r, dual_nxt_s;
   logic            last_s;
   logic            shadow_full_r;
   logic            accept_s, transfer_s, apply_s;

   // Last-cycle detection and next counter/direction state.
   always_comb begin
      last_s     = 1'b0;
      cnt_nxt_s  = cnt_r + CNT_ONE;
      dir_nxt_s  = dir_r;
      max_nxt_s  = max_r;
      dual_nxt_s = dual_r;
      if (max_r == CNT_ZERO) begin
         last_s = 1'b1;
      end else if (!dual_r || (max_r == CNT_ONE)) begin
         last_s = (cnt_r == max_r);
      end else begin
         last_s = (dir_r == DIR_DOWN) && (cnt_r == CNT_ONE);
      end

      if (last_s) begin
         cnt_nxt_s  = CNT_ZERO;
         dir_nxt_s  = DIR_UP;
         max_nxt_s  = compare_max;
         dual_nxt_s = dual_slope_en;
      end else if (!dual_r) begin
         cnt_nxt_s = cnt_r + CNT_ONE;
      end else begin
         case (dir_r)
            DIR_UP: begin
               if (cnt_r == max_r) begin
                  dir_nxt_s = DIR_DOWN;
                  cnt_nxt_s = cnt_r - CNT_ONE;
               end else begin
                  cnt_nxt_s = cnt_r + CNT_ONE;
               end
            end
            DIR_DOWN: cnt_nxt_s = cnt_r - CNT_ONE;
            default: begin
               cnt_nxt_s = CNT_ZERO;
               dir_nxt_s = DIR_UP;
            end
         endcase
      end
   end

   assign accept_s         = pw_bus.pw_valid & ~shadow_full_r;
   assign transfer_s       = last_s & shadow_full_r;
   assign apply_s          = DITHER_EN ? last_s : transfer_s;
   assign pw_bus.pw_ready  = ~shadow_full_r;

   // Counter state, boundary strobe and shadow occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r         <= CNT_ZERO;
         dir_r         <= DIR_UP;
         max_r         <= CNT_ZERO;
         dual_r        <= 1'b0;
         shadow_full_r <= 1'b0;
         pulse_done    <= 1'b0;
      end else begin
         cnt_r      <= cnt_nxt_s;
         dir_r      <= dir_nxt_s;
         max_r      <= max_nxt_s;
         dual_r     <= dual_nxt_s;
         pulse_done <= last_s;
         if (transfer_s) begin
            shadow_full_r <= 1'b0;
         end else if (accept_s) begin
            shadow_full_r <= 1'b1;
         end else begin
            shadow_full_r <= shadow_full_r;
         end
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      pwm_channel #(
         .BITS (BITS),
         .FRAC (FRAC),
         .IN_W (IN_W)
      ) u_ch (
         .clk   (clk),
         .reset (reset),
         .load  (accept_s),
         .apply (apply_s),
         .pw_in (pw_bus.pw_data[i*CH_W + (CH_W - IN_W) +: IN_W]),
         .cnt   (cnt_r),
         .pwm   (pwm_out[i])
      );
   end
endmodule

// File: tb/tb_multichannel_pwm_modulator.sv
// Scoreboard bench: per-period expectations (length, high counts, ch0 shape)
// are queued by the driver and checked whenever pulse_done closes a period.
module tb_multichannel_pwm_modulator;
   localparam int BITS = 11;
   localparam int CH   = 4;
   localparam int FRAC = 4;
   localparam int PW   = BITS + FRAC;

   typedef struct packed {
      logic [31:0] len;
      logic [47:0] hi;
      logic [63:0] pat;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            dual_slope_en;
   logic [BITS-1:0] compare_max;
   logic            pulse_done;
   logic [CH-1:0]   pwm_out;

   multichannel_pwm_modulator_if #(.BITS(BITS), .CHANNELS(CH), .FRAC(FRAC)) pw_bus ();

   multichannel_pwm_modulator #(.BITS(BITS), .CHANNELS(CH), .FRAC(FRAC)) dut (
      .clk           (clk),
      .reset         (reset),
      .dual_slope_en (dual_slope_en),
      .compare_max   (compare_max),
      .pw_bus        (pw_bus),
      .pulse_done    (pulse_done),
      .pwm_out       (pwm_out)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got === want) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic exp_t make_exp(input int mx, input bit dual, input int w0, input int w1,
                                     input int w2, input int w3);
      exp_t e;
      int   w[4];
      int   len;
      int   h;
      w     = '{w0, w1, w2, w3};
      len   = (mx == 0) ? 1 : (dual ? 2 * mx : mx + 1);
      e.len = 32'(len);
      e.hi  = '0;
      e.pat = '0;
      for (int i = 0; i < 4; i++) begin
         if (dual && w[i] >= mx + 1) h = len;
         else if (!dual)             h = (w[i] < len) ? w[i] : len;
         else                        h = (w[i] == 0) ? 0 : 2 * w[i] - 1;
         e.hi[i*12 +: 12] = 12'(h);
      end
      for (int k = 0; k < len && k < 64; k++) begin
         if (!dual) e.pat[k] = (k < w[0]);
         else       e.pat[k] = (w[0] >= mx + 1) || (k < w[0]) || (w[0] > 0 && k >= len - (w[0] - 1));
      end
      return e;
   endfunction

   function automatic logic [CH*PW-1:0] pack_w(input int w0, input int w1, input int w2,
                                                input int w3, input int f);
      int                w[4];
      logic [CH*PW-1:0]  d;
      w = '{w0, w1, w2, w3};
      d = '0;
      for (int i = 0; i < CH; i++) d[i*PW +: PW] = {11'(w[i]), 4'(f)};
      return d;
   endfunction

   // Monitor: accumulate one period of output and compare at its pulse_done.
   initial begin
      int          m_len;
      int          m_hi[4];
      logic [63:0] m_pat;
      exp_t        e;
      m_len = 0; m_pat = '0;
      for (int i = 0; i < 4; i++) m_hi[i] = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            m_len = 0; m_pat = '0;
            for (int i = 0; i < 4; i++) m_hi[i] = 0;
         end else begin
            if (m_len < 64) m_pat[m_len] = pwm_out[0];
            for (int i = 0; i < 4; i++) if (pwm_out[i]) m_hi[i]++;
            m_len++;
            if (pulse_done) begin
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  check_eq("period_len", 64'(m_len), 64'(e.len));
                  for (int i = 0; i < 4; i++) check_eq("high_count", 64'(m_hi[i]), 64'(e.hi[i*12 +: 12]));
                  check_eq("ch0_shape", m_pat, e.pat);
               end
               m_len = 0; m_pat = '0;
               for (int i = 0; i < 4; i++) m_hi[i] = 0;
            end
         end
      end
   end

   task automatic wait_done(input int budget);
      int n = 0;
      @(negedge clk);
      while (!pulse_done && n < budget) begin @(negedge clk); n++; end
      if (!pulse_done) check_eq("pulse_done_timeout", 64'd0, 64'd1);
   endtask

   task automatic sync(input int periods);
      repeat (periods) wait_done(5000);
      @(posedge clk); #1;
   endtask

   task automatic wait_empty();
      int n = 0;
      while (sb.size() > 0 && n < 20000) begin @(negedge clk); n++; end
      if (sb.size() > 0) check_eq("drain_timeout", 64'(sb.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic write_w(input logic [CH*PW-1:0] data);
      int n = 0;
      pw_bus.pw_data  = data;
      pw_bus.pw_valid = 1'b1;
      @(negedge clk);
      while (!pw_bus.pw_ready && n < 5000) begin @(negedge clk); n++; end
      if (!pw_bus.pw_ready) check_eq("write_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      pw_bus.pw_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int cfg [8][6] = '{
      '{9, 0, 3, 3, 3, 3},
      '{8, 1, 4, 4, 4, 4},
      '{8, 1, 1, 8, 9, 0},
      '{9, 0, 0, 3, 9, 2047},
      '{0, 0, 0, 1, 5, 2047},
      '{0, 1, 0, 1, 5, 2047},
      '{1, 1, 0, 1, 2, 3},
      '{5, 0, 6, 5, 1, 2}
   };

   initial begin
      int   held;
      reset           = 1'b1;
      dual_slope_en   = 1'b0;
      compare_max     = '0;
      pw_bus.pw_valid = 1'b0;
      pw_bus.pw_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_pwm_out", 64'(pwm_out), 64'd0);
      check_eq("rst_pulse_done", 64'(pulse_done), 64'd0);
      check_eq("rst_pw_ready", 64'(pw_bus.pw_ready), 64'd1);
      reset = 1'b0;
      @(posedge clk); #1;
      check_eq("post_rst_pw_ready", 64'(pw_bus.pw_ready), 64'd1);

      // Configuration table: slopes, widths and edge cases.
      foreach (cfg[t]) begin
         compare_max   = 11'(cfg[t][0]);
         dual_slope_en = cfg[t][1][0];
         write_w(pack_w(cfg[t][2], cfg[t][3], cfg[t][4], cfg[t][5], 0));
         sync(2);
         repeat (3) sb.push_back(make_exp(cfg[t][0], cfg[t][1][0], cfg[t][2], cfg[t][3], cfg[t][4], cfg[t][5]));
         wait_empty();
      end

      // Handshake: mid-period write, hold-off of a second write.
      compare_max   = 11'd9;
      dual_slope_en = 1'b0;
      write_w(pack_w(3, 3, 3, 3, 0));
      sync(2);
      sb.push_back(make_exp(9, 1'b0, 3, 3, 3, 3));
      repeat (4) @(posedge clk);
      #1;
      check_eq("hs_idle_ready", 64'(pw_bus.pw_ready), 64'd1);
      write_w(pack_w(5, 5, 5, 5, 0));
      check_eq("hs_busy_ready", 64'(pw_bus.pw_ready), 64'd0);
      sb.push_back(make_exp(9, 1'b0, 5, 5, 5, 5));
      pw_bus.pw_data  = pack_w(6, 6, 6, 6, 0);
      pw_bus.pw_valid = 1'b1;
      held = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (pulse_done) break;
         if (pw_bus.pw_ready) held = 1;
      end
      check_eq("hs_hold_off", 64'(held), 64'd0);
      check_eq("hs_boundary_ready", 64'(pw_bus.pw_ready), 64'd1);
      @(posedge clk); #1;
      pw_bus.pw_valid = 1'b0;
      check_eq("hs_second_busy", 64'(pw_bus.pw_ready), 64'd0);
      sb.push_back(make_exp(9, 1'b0, 6, 6, 6, 6));
      wait_empty();

      // Reset mid-period with a full shadow.
      sync(1);
      repeat (3) @(posedge clk);
      #1;
      write_w(pack_w(7, 7, 7, 7, 0));
      check_eq("pre_rst_full", 64'(pw_bus.pw_ready), 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      check_eq("midrst_pwm_out", 64'(pwm_out), 64'd0);
      check_eq("midrst_pulse_done", 64'(pulse_done), 64'd0);
      check_eq("midrst_pw_ready", 64'(pw_bus.pw_ready), 64'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check_eq("midrst_ready_after", 64'(pw_bus.pw_ready), 64'd1);
      sync(2);
      repeat (2) sb.push_back(make_exp(9, 1'b0, 0, 0, 0, 0));
      wait_empty();

      // Fractional field: dithered when enabled, ignored otherwise.
      compare_max = 11'd9;
      write_w(pack_w(3, 3, 3, 3, 4));
      sync(2);
`ifdef PWM_DITHER_EN
      begin
         int n3, n4, hi;
         n3 = 0; n4 = 0;
         for (int p = 0; p < 16; p++) begin
            hi = 0;
            for (int n = 0; n < 100; n++) begin
               @(negedge clk);
               if (pwm_out[0]) hi++;
               if (pulse_done) break;
            end
            if (hi == 4) n4++;
            else if (hi == 3) n3++;
         end
         check_eq("dither_periods_of_4", 64'(n4), 64'd4);
         check_eq("dither_periods_of_3", 64'(n3), 64'd12);
      end
      @(posedge clk); #1;
      compare_max = 11'd2047;
      write_w(pack_w(2047, 2047, 2047, 2047, 15));
      sync(2);
      repeat (2) sb.push_back(make_exp(2047, 1'b0, 2047, 2047, 2047, 2047));
      wait_empty();
`else
      repeat (4) sb.push_back(make_exp(9, 1'b0, 3, 3, 3, 3));
      wait_empty();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
